// File: rtl/reg_dump_reader.sv
// Streams a contiguous range of register-file words out as bytes, optionally
// preceded by the register index, over a valid/ready byte interface.
//
// state     | meaning
// ----------|------------------------------------------------------------
// IDLE      | waiting for start_i; rf_addr_o parked at 0
// FETCH     | one cycle: capture rf_data_i for cur_idx into the word register
// SEND_IDX  | present {3'b000, cur_idx} until accepted
// SEND_DATA | present byte k of the captured word (LSB first) until accepted
// DONE      | one-cycle done_o pulse, then back to IDLE
module reg_dump_reader #(
    parameter int unsigned SEND_INDEX = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [4:0]  first_i,
    input  logic [4:0]  last_i,
    output logic [5:0]  rf_addr_o,
    input  logic [31:0] rf_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_SEND_IDX  = 3'd2,
        S_SEND_DATA = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t      state_q,   state_d;
    logic [4:0]  cur_idx_q, cur_idx_d;
    logic [4:0]  end_idx_q, end_idx_d;
    logic [1:0]  k_q,       k_d;
    logic [31:0] word_q,    word_d;
    logic [7:0]  data_byte;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cur_idx_q <= 5'd0;
            end_idx_q <= 5'd0;
            k_q       <= 2'd0;
            word_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            cur_idx_q <= cur_idx_d;
            end_idx_q <= end_idx_d;
            k_q       <= k_d;
            word_q    <= word_d;
        end
    end

    always_comb begin
        data_byte = 8'd0;
        case (k_q)
            2'd0:    data_byte = word_q[7:0];
            2'd1:    data_byte = word_q[15:8];
            2'd2:    data_byte = word_q[23:16];
            default: data_byte = word_q[31:24];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cur_idx_d  = cur_idx_q;
        end_idx_d  = end_idx_q;
        k_d        = k_q;
        word_d     = word_q;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'd0;
        done_o     = 1'b0;
        busy_o     = (state_q != S_IDLE);
        rf_addr_o  = (state_q == S_IDLE) ? 6'd0 : {1'b0, cur_idx_q};

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (first_i <= last_i) begin
                        cur_idx_d = first_i;
                        end_idx_d = last_i;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                // The word is frozen here so later register writes cannot
                // tear a partially sent value.
                word_d  = rf_data_i;
                k_d     = 2'd0;
                state_d = (SEND_INDEX != 0) ? S_SEND_IDX : S_SEND_DATA;
            end
            S_SEND_IDX: begin
                tx_valid_o = 1'b1;
                tx_data_o  = {3'b000, cur_idx_q};
                if (tx_ready_i) begin
                    k_d     = 2'd0;
                    state_d = S_SEND_DATA;
                end
            end
            S_SEND_DATA: begin
                tx_valid_o = 1'b1;
                tx_data_o  = data_byte;
                if (tx_ready_i) begin
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        // Equality, not '>', so a range ending at 31 stops
                        // instead of wrapping back to index 0.
                        if (cur_idx_q == end_idx_q) begin
                            state_d = S_DONE;
                        end else begin
                            cur_idx_d = cur_idx_q + 5'd1;
                            state_d   = S_FETCH;
                        end
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized scoreboard bench for reg_dump_reader: a reference model queues the
// expected byte stream and done pulses, a monitor consumes them as they appear.
module tb_reg_dump_reader;

    localparam int SEND_INDEX = 1;
    localparam int PER_REG    = (SEND_INDEX != 0) ? 6 : 5;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [4:0]  first_i;
    logic [4:0]  last_i;
    logic [5:0]  rf_addr_o;
    logic [31:0] rf_data_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        busy_o;
    logic        done_o;

    logic [31:0] rf_mem [32];
    logic [7:0]  exp_q [$];
    int          exp_done;
    int          n_checks;
    int          n_fail;
    int          bp_mode;   // 0: ready=1, 1: ready 30% random, 2: ready=0

    always #5 clk_i = ~clk_i;

    assign rf_data_i = rf_mem[rf_addr_o[4:0]];

    reg_dump_reader #(.SEND_INDEX(SEND_INDEX)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (start_i),
        .first_i    (first_i),
        .last_i     (last_i),
        .rf_addr_o  (rf_addr_o),
        .rf_data_i  (rf_data_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stream is simply, for each index in the range,
    // the optional index byte followed by the word's four bytes LSB first.
    task automatic push_expect(input int f, input int l);
        logic [31:0] w;
        if (f <= l) begin
            for (int i = f; i <= l; i++) begin
                if (SEND_INDEX != 0) exp_q.push_back(i[7:0]);
                w = rf_mem[i];
                for (int b = 0; b < 4; b++) exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
            end
        end
        exp_done++;
    endtask

    function automatic int expected_cycles(input int f, input int l);
        return (f <= l) ? 1 + (l - f + 1) * PER_REG : 1;
    endfunction

    always @(posedge clk_i) begin
        #1;
        case (bp_mode)
            0:       tx_ready_i = 1'b1;
            1:       tx_ready_i = ($urandom_range(0, 99) < 30);
            default: tx_ready_i = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on each transfer and checks hold-while-stalled.
    initial begin : monitor
        logic       stall_seen;
        logic [7:0] stall_data;
        logic [7:0] e;
        stall_seen = 1'b0;
        stall_data = 8'd0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                stall_seen = 1'b0;
            end else begin
                if (stall_seen) begin
                    check("hold_valid", {31'd0, tx_valid_o}, 32'd1);
                    check("hold_data", {24'd0, tx_data_o}, {24'd0, stall_data});
                end
                if (tx_valid_o && tx_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected none at %0t", tx_data_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_byte", {24'd0, tx_data_o}, {24'd0, e});
                    end
                end
                stall_seen = tx_valid_o && !tx_ready_i;
                stall_data = tx_data_o;
                if (done_o) begin
                    check("done_expected", {31'd0, (exp_done > 0)}, 32'd1);
                    check("done_bytes_left", exp_q.size(), 32'd0);
                    if (exp_done > 0) exp_done--;
                end
            end
        end
    end

    task automatic start_dump(input int f, input int l, input bit hold);
        int guard;
        guard = 0;
        while (busy_o && guard < 5000) begin
            @(negedge clk_i);
            guard++;
        end
        check("idle_before_start", {31'd0, busy_o}, 32'd0);
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
        first_i = f[4:0];
        last_i  = l[4:0];
        push_expect(f, l);
        @(posedge clk_i);
        #1;
        if (!hold) start_i = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done_o; first_v is the
    // cycle of the first valid byte, busy_n the cycles with busy_o high.
    task automatic wait_done(output int cyc, output int first_v, output int busy_n);
        cyc = 0;
        first_v = 0;
        busy_n = 0;
        for (int i = 1; i <= 4000; i++) begin
            @(negedge clk_i);
            if (busy_o) busy_n++;
            if (tx_valid_o && first_v == 0) first_v = i;
            if (done_o) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done_o, expected one within 4000 cycles");
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no end of test, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cyc, fv, bn, f, l;
        n_checks = 0;
        n_fail   = 0;
        exp_done = 0;
        bp_mode  = 0;
        rst_n_i  = 1'b0;
        start_i  = 1'b0;
        first_i  = 5'd0;
        last_i   = 5'd0;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        rf_mem[0] = 32'd0;

        #3;
        check("rst_valid", {31'd0, tx_valid_o}, 32'd0);
        check("rst_data", {24'd0, tx_data_o}, 32'd0);
        check("rst_addr", {26'd0, rf_addr_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        // Scenario 1: single register with index, exact timing.
        rf_mem[5] = 32'hDEADBEEF;
        start_dump(5, 5, 1'b0);
        wait_done(cyc, fv, bn);
        check("s1_first_valid", fv, 32'd2);
        check("s1_done_cycle", cyc, 32'd7);
        check("s1_busy_cycles", bn, 32'd7);

        // Scenario 2: top of the index range, no wrap to 0.
        rf_mem[30] = 32'h11223344;
        rf_mem[31] = 32'hA5A5A5A5;
        start_dump(30, 31, 1'b0);
        wait_done(cyc, fv, bn);
        check("s2_done_cycle", cyc, expected_cycles(30, 31));
        @(negedge clk_i);
        check("s2_idle_after", {31'd0, busy_o}, 32'd0);

        // Scenario 4: empty range; start held into DONE must be ignored.
        start_dump(7, 2, 1'b1);
        wait_done(cyc, fv, bn);
        check("s4_done_cycle", cyc, 32'd1);
        check("s4_no_valid", fv, 32'd0);
        check("s4_busy_cycles", bn, 32'd1);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(negedge clk_i);
        check("s4_start_ignored_in_done", {31'd0, busy_o}, 32'd0);

        // Register 0 reads like any other, and full-speed latency formula.
        start_dump(0, 1, 1'b0);
        wait_done(cyc, fv, bn);
        check("r0_done_cycle", cyc, expected_cycles(0, 1));
        for (int it = 0; it < 3; it++) begin
            for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;
            f = $urandom_range(0, 31);
            l = $urandom_range(f, 31);
            start_dump(f, l, 1'b0);
            wait_done(cyc, fv, bn);
            check("rand_done_cycle", cyc, expected_cycles(f, l));
            check("rand_first_valid", fv, 32'd2);
        end

        // Scenario 3: 30% ready backpressure, small and large ranges.
        bp_mode = 1;
        for (int it = 0; it < 10; it++) begin
            for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;
            if (it < 6) begin
                f = $urandom_range(0, 3);
                l = $urandom_range(0, 3);
            end else begin
                f = $urandom_range(0, 31);
                l = $urandom_range(0, 31);
            end
            start_dump(f, l, 1'b0);
            wait_done(cyc, fv, bn);
        end

        // Scenario 5: register write after capture must not alter the word.
        bp_mode = 2;
        rf_mem[9] = 32'h1;
        @(posedge clk_i);
        start_dump(9, 9, 1'b0);
        repeat (4) @(negedge clk_i);
        rf_mem[9] = 32'h2;
        repeat (2) @(negedge clk_i);
        bp_mode = 0;
        wait_done(cyc, fv, bn);

        // Scenario 6: reset in the middle of SEND_DATA, then restart.
        for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;
        start_dump(0, 3, 1'b0);
        repeat (8) @(negedge clk_i);
        @(posedge clk_i);
        #2;
        check("s6_pre_valid", {31'd0, tx_valid_o}, 32'd1);
        rst_n_i = 1'b0;
        #1;
        check("s6_valid", {31'd0, tx_valid_o}, 32'd0);
        check("s6_data", {24'd0, tx_data_o}, 32'd0);
        check("s6_addr", {26'd0, rf_addr_o}, 32'd0);
        check("s6_busy", {31'd0, busy_o}, 32'd0);
        check("s6_done", {31'd0, done_o}, 32'd0);
        exp_q.delete();
        exp_done = 0;
        start_i = 1'b1;
        first_i = 5'd2;
        last_i  = 5'd4;
        push_expect(2, 4);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done(cyc, fv, bn);
        check("s6_restart_first_valid", fv, 32'd2);
        check("s6_restart_done_cycle", cyc, expected_cycles(2, 4));

        repeat (3) @(negedge clk_i);
        check("end_queue_empty", exp_q.size(), 32'd0);
        check("end_done_balance", exp_done, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
